// File: rtl/tlc_intersection.sv
`default_nettype none
// ============================================================================
// Module  : tlc_intersection
// Brief   : Multi-phase traffic-light controller. Phases cycle through
//           GREEN -> YELLOW -> ALLRED with per-phase green times. Supports
//           freeze (stop), reload (set) and out-of-order phase requests (jump).
// Revision: 1.0 - initial release
// ============================================================================
module tlc_intersection #(
  parameter int NPH = 4,
  parameter int TW  = 6,
  parameter int PW  = $clog2(NPH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic              stop,
  input  logic              jump,
  input  logic [PW-1:0]     jump_phase,
  input  logic [NPH*TW-1:0] g_time,
  input  logic [TW-1:0]     y_time,
  input  logic [TW-1:0]     ar_time,
  output logic [NPH-1:0]    g_out,
  output logic [NPH-1:0]    y_out,
  output logic [NPH-1:0]    r_out,
  output logic [PW-1:0]     cur_phase,
  output logic [TW-1:0]     remain
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } state_t;

  // Phase count widened by one bit so it can be compared against any index.
  localparam logic [PW:0]   c_nph     = (PW+1)'(NPH);
  localparam logic [PW-1:0] c_last_ph = PW'(NPH-1);

  state_t              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic                pend_vld_q, pend_vld_d;
  logic [PW-1:0]       pend_ph_q, pend_ph_d;
  logic [NPH*TW-1:0]   gdur_q, gdur_d;
  logic [TW-1:0]       ydur_q, ydur_d;
  logic [TW-1:0]       ardur_q, ardur_d;

  logic [TW-1:0]       w_g_raw;
  logic [TW-1:0]       w_len;
  logic                w_last;
  logic                w_jump_ok;
  logic [PW-1:0]       w_next_ph;
  logic [PW-1:0]       w_green_ph;
  logic [NPH-1:0]      w_g;
  logic [NPH-1:0]      w_y;

  // Interval length of the current state; zero durations for G/Y act as one.
  always_comb begin
    w_g_raw = gdur_q[TW*int'(phase_q) +: TW];
    w_len   = '0;
    case (state_q)
      GREEN:   w_len = (w_g_raw == '0) ? TW'(1) : w_g_raw;
      YELLOW:  w_len = (ydur_q == '0) ? TW'(1) : ydur_q;
      ALLRED:  w_len = ardur_q;
      default: w_len = '0;
    endcase
    w_last     = (cnt_q == (w_len - TW'(1)));
    w_jump_ok  = jump && ({1'b0, jump_phase} < c_nph);
    w_next_ph  = (phase_q == c_last_ph) ? '0 : phase_q + PW'(1);
    // A jump arriving on the very edge that enters GREEN is honoured directly.
    w_green_ph = w_jump_ok ? jump_phase : (pend_vld_q ? pend_ph_q : w_next_ph);
  end

  // Next-state logic: set overrides everything, stop only freezes timing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    pend_vld_d = pend_vld_q;
    pend_ph_d  = pend_ph_q;
    gdur_d     = gdur_q;
    ydur_d     = ydur_q;
    ardur_d    = ardur_q;

    if (set) begin
      gdur_d     = g_time;
      ydur_d     = y_time;
      ardur_d    = ar_time;
      state_d    = GREEN;
      phase_d    = '0;
      cnt_d      = '0;
      pend_vld_d = 1'b0;
    end else begin
      case (state_q)
        GREEN: begin
          if (w_jump_ok && (jump_phase != phase_q)) begin
            state_d    = YELLOW;
            cnt_d      = '0;
            pend_vld_d = 1'b1;
            pend_ph_d  = jump_phase;
          end else if (!stop) begin
            if (w_last) begin
              state_d = YELLOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + TW'(1);
            end
          end
        end
        YELLOW, ALLRED: begin
          if (w_jump_ok) begin
            pend_vld_d = 1'b1;
            pend_ph_d  = jump_phase;
          end
          if (!stop) begin
            if (w_last) begin
              cnt_d = '0;
              if ((state_q == YELLOW) && (ardur_q != '0)) begin
                state_d = ALLRED;
              end else begin
                state_d    = GREEN;
                phase_d    = w_green_ph;
                pend_vld_d = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + TW'(1);
            end
          end
        end
        default: begin
          // IDLE waits for set; jump and stop have nothing to act on.
        end
      endcase
    end
  end

  // State register with asynchronous reset to the all-red idle condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_ph_q  <= '0;
      gdur_q     <= '0;
      ydur_q     <= '0;
      ardur_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      pend_vld_q <= pend_vld_d;
      pend_ph_q  <= pend_ph_d;
      gdur_q     <= gdur_d;
      ydur_q     <= ydur_d;
      ardur_q    <= ardur_d;
    end
  end

  // Moore lamp decode: only the served phase can be green or yellow.
  always_comb begin
    w_g = '0;
    w_y = '0;
    for (int p = 0; p < NPH; p++) begin
      if (phase_q == PW'(p)) begin
        w_g[p] = (state_q == GREEN);
        w_y[p] = (state_q == YELLOW);
      end
    end
    g_out     = w_g;
    y_out     = w_y;
    r_out     = ~(w_g | w_y);
    cur_phase = phase_q;
    remain    = (state_q == IDLE) ? '0 : (w_len - cnt_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_tlc_intersection.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlc_intersection
// Brief   : Scoreboard bench for tlc_intersection. Each scenario pushes the
//           expected per-cycle lamp/phase/remain values, then steps the clock
//           and compares every cycle against the popped expectation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tlc_intersection;

  localparam int NPH = 4;
  localparam int TW  = 6;
  localparam int PW  = 2;

  localparam int K_IDLE = 0;
  localparam int K_G    = 1;
  localparam int K_Y    = 2;
  localparam int K_AR   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              set;
  logic              stop;
  logic              jump;
  logic [PW-1:0]     jump_phase;
  logic [NPH*TW-1:0] g_time;
  logic [TW-1:0]     y_time;
  logic [TW-1:0]     ar_time;
  logic [NPH-1:0]    g_out;
  logic [NPH-1:0]    y_out;
  logic [NPH-1:0]    r_out;
  logic [PW-1:0]     cur_phase;
  logic [TW-1:0]     remain;

  tlc_intersection #(.NPH(NPH), .TW(TW), .PW(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .set        (set),
    .stop       (stop),
    .jump       (jump),
    .jump_phase (jump_phase),
    .g_time     (g_time),
    .y_time     (y_time),
    .ar_time    (ar_time),
    .g_out      (g_out),
    .y_out      (y_out),
    .r_out      (r_out),
    .cur_phase  (cur_phase),
    .remain     (remain)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int ph;
    int rem;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_e(input int k, input int p, input int r);
    exp_t e;
    e.kind = k;
    e.ph   = p;
    e.rem  = r;
    sb.push_back(e);
  endtask

  // One whole interval: remain counts n down to 1.
  task automatic push_iv(input int k, input int p, input int n);
    for (int i = 0; i < n; i++) push_e(k, p, n - i);
  endtask

  task automatic compare_now();
    exp_t           e;
    logic [NPH-1:0] eg;
    logic [NPH-1:0] ey;
    logic [NPH-1:0] er;
    int             bad;
    chk("sb_avail", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e  = sb.pop_front();
    eg = '0;
    ey = '0;
    if (e.kind == K_G) eg[e.ph] = 1'b1;
    if (e.kind == K_Y) ey[e.ph] = 1'b1;
    er = ~(eg | ey);
    chk("g_out", 32'(g_out), 32'(eg));
    chk("y_out", 32'(y_out), 32'(ey));
    chk("r_out", 32'(r_out), 32'(er));
    chk("cur_phase", 32'(cur_phase), 32'(e.ph));
    chk("remain", 32'(remain), 32'(e.rem));
    bad = 0;
    for (int p = 0; p < NPH; p++) begin
      if ((int'(g_out[p]) + int'(y_out[p]) + int'(r_out[p])) != 1) bad++;
    end
    chk("lamp_onehot", 32'(bad), 32'd0);
    chk("nonred_le1", 32'($countones(~r_out) > 1), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    compare_now();
  endtask

  task automatic drain();
    while (sb.size() > 0) step();
  endtask

  task automatic do_set(input logic [NPH*TW-1:0] g, input logic [TW-1:0] y, input logic [TW-1:0] ar);
    set     = 1'b1;
    g_time  = g;
    y_time  = y;
    ar_time = ar;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; set = 1'b0; stop = 1'b0; jump = 1'b0; jump_phase = '0;
    g_time = '0; y_time = '0; ar_time = '0;

    // Reset state, held across edges, then idle after release.
    #2;
    push_e(K_IDLE, 0, 0);
    compare_now();
    push_e(K_IDLE, 0, 0); push_e(K_IDLE, 0, 0);
    step(); step();
    reset = 1'b0;
    push_e(K_IDLE, 0, 0); push_e(K_IDLE, 0, 0);
    drain();

    // Full rotation with wrap; later input changes must be ignored.
    do_set({6'd5, 6'd4, 6'd3, 6'd2}, 6'd3, 6'd1);
    push_iv(K_G, 0, 2); push_iv(K_Y, 0, 3); push_iv(K_AR, 0, 1);
    push_iv(K_G, 1, 3); push_iv(K_Y, 1, 3); push_iv(K_AR, 1, 1);
    push_iv(K_G, 2, 4); push_iv(K_Y, 2, 3); push_iv(K_AR, 2, 1);
    push_iv(K_G, 3, 5); push_iv(K_Y, 3, 3); push_iv(K_AR, 3, 1);
    push_iv(K_G, 0, 2);
    step();
    set = 1'b0; g_time = '1; y_time = '0; ar_time = '0;
    drain();

    // Freeze mid-green at remain=2, then set while stopped.
    do_set({6'd5, 6'd4, 6'd3, 6'd4}, 6'd3, 6'd1);
    push_e(K_G, 0, 4); push_e(K_G, 0, 3); push_e(K_G, 0, 2);
    step(); set = 1'b0; step(); step();
    stop = 1'b1;
    repeat (4) push_e(K_G, 0, 2);
    repeat (4) step();
    stop = 1'b0;
    push_e(K_G, 0, 1); push_iv(K_Y, 0, 3); push_iv(K_AR, 0, 1); push_iv(K_G, 1, 3);
    drain();
    stop = 1'b1;
    do_set({6'd5, 6'd4, 6'd3, 6'd4}, 6'd3, 6'd1);
    push_e(K_G, 0, 4); step();
    set = 1'b0;
    push_e(K_G, 0, 4); step();
    stop = 1'b0;
    push_e(K_G, 0, 3); step();

    // Jump during green: own phase ignored, other phase forces yellow.
    do_set({6'd5, 6'd4, 6'd3, 6'd6}, 6'd2, 6'd2);
    push_e(K_G, 0, 6); push_e(K_G, 0, 5);
    step(); set = 1'b0; step();
    jump = 1'b1; jump_phase = 2'd0;
    push_e(K_G, 0, 4); step();
    jump_phase = 2'd3;
    push_iv(K_Y, 0, 2); step();
    jump = 1'b0;
    push_iv(K_AR, 0, 2); push_iv(K_G, 3, 5); push_iv(K_Y, 3, 2); push_iv(K_AR, 3, 2);
    push_e(K_G, 0, 6);
    drain();

    // Jump in yellow records/overwrites; set+jump together clears it.
    do_set({4{6'd1}}, 6'd3, 6'd1);
    push_e(K_G, 0, 1); push_e(K_Y, 0, 3);
    step(); set = 1'b0; step();
    jump = 1'b1; jump_phase = 2'd2;
    push_e(K_Y, 0, 2); step();
    jump_phase = 2'd3;
    push_e(K_Y, 0, 1); step();
    jump = 1'b0;
    push_iv(K_AR, 0, 1); push_iv(K_G, 3, 1); push_iv(K_Y, 3, 3); push_iv(K_AR, 3, 1);
    push_iv(K_G, 0, 1); push_iv(K_Y, 0, 3); push_iv(K_AR, 0, 1);
    push_iv(K_G, 1, 1); push_iv(K_Y, 1, 3); push_iv(K_AR, 1, 1);
    push_iv(K_G, 2, 1); push_e(K_Y, 2, 3);
    drain();
    do_set({4{6'd1}}, 6'd3, 6'd1);
    jump = 1'b1; jump_phase = 2'd3;
    push_e(K_G, 0, 1); step();
    set = 1'b0; jump = 1'b0;
    push_iv(K_Y, 0, 3); push_iv(K_AR, 0, 1); push_iv(K_G, 1, 1);
    drain();

    // Zero green/yellow act as one cycle; zero all-red skips ALLRED.
    do_set({6'd2, 6'd2, 6'd2, 6'd0}, 6'd0, 6'd0);
    push_e(K_G, 0, 1); step();
    set = 1'b0;
    push_iv(K_Y, 0, 1); push_iv(K_G, 1, 2); push_iv(K_Y, 1, 1); push_iv(K_G, 2, 2);
    push_iv(K_Y, 2, 1); push_iv(K_G, 3, 2); push_iv(K_Y, 3, 1); push_iv(K_G, 0, 1);
    drain();

    // Asynchronous reset mid-yellow, idle until the next set.
    do_set({6'd5, 6'd4, 6'd3, 6'd2}, 6'd3, 6'd1);
    push_iv(K_G, 0, 2); push_e(K_Y, 0, 3); push_e(K_Y, 0, 2);
    step(); set = 1'b0;
    drain();
    #2;
    reset = 1'b1;
    #1;
    push_e(K_IDLE, 0, 0); compare_now();
    push_e(K_IDLE, 0, 0); step();
    reset = 1'b0;
    push_e(K_IDLE, 0, 0); push_e(K_IDLE, 0, 0); push_e(K_IDLE, 0, 0);
    drain();
    do_set({6'd5, 6'd4, 6'd3, 6'd2}, 6'd3, 6'd1);
    push_e(K_G, 0, 2); step();
    set = 1'b0;
    push_e(K_G, 0, 1); push_iv(K_Y, 0, 3);
    drain();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
